legv8_mmio_unit: RTL
====================

// Module: legv8_mmio_unit
// PURPOSE
//   Memory-mapped I/O stage directly downstream of the LegV8 datapath's memory port.
//   Decodes datapath address/data/write/enable into a byte TX FIFO, a compare-match timer and a control/status block.
//   Returns read data on datain in the same cycle.
//   Off-window accesses are left to data RAM; this block drives datain=0 for them.
// PARAMETERS
//   MMIO_BASE   64'h0000_0000_0000_1000  base of 64-byte register window (64-byte aligned)
//   FIFO_DEPTH  4                        TX FIFO entries (power of 2, >=2)
// PORTS
//   clock      in   1   rising-edge clock
//   reset      in   1   synchronous, active-low reset
//   address    in   64  datapath memory address
//   data       in   64  datapath write data
//   mem_write  in   1   1=write, 0=read (qualified by EN_MEM)
//   EN_MEM     in   1   memory access strobe for this cycle
//   datain     out  64  read data to datapath (combinational)
//   tx_data    out  8   FIFO head byte
//   tx_valid   out  1   FIFO non-empty
//   tx_ready   in   1   downstream accepts tx_data this cycle
//   timer_irq  out  1   irq_pending & CTRL.irq_en
// BEHAVIOUR
//   Decode: hit = EN_MEM & (address[63:6]==MMIO_BASE[63:6]); reg = address[5:3]; address[2:0] ignored.
//   Register map:
//     0 TXDATA    W: push data[7:0]; R: 0
//     1 STATUS    R: {count[7:0] @15:8, overflow @3, irq_pending @2, full @1, empty @0}; W: bit3=1 clears overflow
//     2 TIMER_CNT R/W 64-bit
//     3 TIMER_CMP R/W 64-bit
//     4 CTRL      R/W bit0 timer_en, bit1 irq_en; W bit2=1 clears irq_pending (bit2 reads 0)
//     5-7 reserved: R 0, W ignored
//   Reads: datain = selected register when hit & ~mem_write; otherwise 64'b0. Zero latency.
//   Writes: take effect at the rising edge on which hit & mem_write.
//   Reset (reset==0 at edge): FIFO emptied, count=0, overflow=0, TIMER_CNT=0, TIMER_CMP=64'hFFFF_FFFF_FFFF_FFFF.
//     Also CTRL=0, irq_pending=0; hence tx_valid=0, timer_irq=0, tx_data=0.
//   Reset overrides any same-cycle write or pop; a pending FIFO entry is discarded.
//   FIFO:
//     pop = tx_valid & tx_ready; push = TXDATA write.
//     Push accepted when count<FIFO_DEPTH, or when full and pop in same cycle.
//     Push rejected when full with no pop: byte dropped, overflow set (sticky).
//     Simultaneous accepted push+pop: count unchanged; head advances; new byte written at tail.
//     Read/write pointers wrap modulo FIFO_DEPTH. tx_data = head entry; holds while tx_ready=0.
//     tx_data reads 0 when empty.
//   Timer (per cycle, priority high->low):
//     1. TIMER_CNT write: CNT <= data.
//     2. timer_en & CNT==CMP: CNT <= 0, irq_pending <= 1.
//     3. timer_en: CNT <= CNT+1 (wraps 2^64-1 -> 0).
//     Timer disabled: CNT holds.
//     A TIMER_CNT write suppresses that cycle's match.
//     Match and CTRL clear in the same cycle: set wins, irq_pending=1.
//   STATUS.overflow clear and new overflow in the same cycle: overflow stays 1.
// TESTING
//   Reset held 2 cycles then released -> datain=0, tx_valid=0, timer_irq=0; STATUS read = 64'h1.
//   Write 8'hA5, 8'h5A to TXDATA (0x1000), tx_ready=0
//     -> tx_valid=1, tx_data=A5; STATUS=64'h0200.
//     Then tx_ready=1 for 1 cycle -> tx_data=5A.
//   Fill FIFO with 4 bytes, 5th write with tx_ready=0 -> 5th dropped, STATUS=64'h040A.
//     Write STATUS 0x8 -> overflow=0.
//   Full FIFO, write + tx_ready=1 in same cycle -> count stays 4, new byte last out, no overflow.
//   CMP=3, CTRL=3 -> CNT 0,1,2,3,0; irq_pending set on 3->0 edge, timer_irq=1.
//     CTRL write 0x7 -> irq cleared next edge.
//   CNT=64'hFFFF_FFFF_FFFF_FFFF, CMP=5, enabled -> CNT wraps to 0 with no irq;
//     irq_pending set on the edge where CNT 5->0.
//   Read 0x1030 (reserved) or 0x2000 (off-window) -> datain=0; EN_MEM=0 with hit address -> datain=0, no push.

Source files
------------

// File: rtl/legv8_mmio_unit.sv
// Memory-mapped I/O block for the LegV8 datapath memory port.
// It provides a byte TX FIFO, a compare-match timer and control/status registers.
module legv8_mmio_unit #(
   parameter logic [63:0] MMIO_BASE  = 64'h0000_0000_0000_1000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [63:0] address,
   input  logic [63:0] data,
   input  logic        mem_write,
   input  logic        EN_MEM,
   output logic [63:0] datain,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        timer_irq
);

   localparam int          PW      = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      REG_TXDATA    = 3'd0,
      REG_STATUS    = 3'd1,
      REG_TIMER_CNT = 3'd2,
      REG_TIMER_CMP = 3'd3,
      REG_CTRL      = 3'd4
   } reg_e;

   logic          hit;
   logic [2:0]    sel;
   logic          wr;
   logic          rd;
   logic          unused_addr_bits;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          push_ok;
   logic          overflow_set;
   logic          overflow;

   logic [63:0]   cnt;
   logic [63:0]   cmp;
   logic          timer_en;
   logic          irq_en;
   logic          irq_pending;
   logic          cnt_wr;
   logic          ctrl_wr;
   logic          match;

   // Only 8-byte granularity is decoded; the byte offset inside a register is ignored.
   assign unused_addr_bits = &{1'b0, address[2:0]};

   assign hit = EN_MEM & (address[63:6] == MMIO_BASE[63:6]);
   assign sel = address[5:3];
   assign wr  = hit & mem_write;
   assign rd  = hit & ~mem_write;

   assign empty        = (count == '0);
   assign full         = (count == DEPTH_C);
   assign tx_valid     = ~empty;
   assign pop          = tx_valid & tx_ready;
   assign push         = wr & (sel == REG_TXDATA);
   // A push into a full FIFO still fits if the head leaves in the same cycle.
   assign push_ok      = push & (~full | pop);
   assign overflow_set = push & full & ~pop;
   assign tx_data      = empty ? 8'h00 : fifo_mem[rd_ptr];

   assign cnt_wr    = wr & (sel == REG_TIMER_CNT);
   assign ctrl_wr   = wr & (sel == REG_CTRL);
   assign match     = timer_en & (cnt == cmp) & ~cnt_wr;
   assign timer_irq = irq_pending & irq_en;

   // NOTE: storage is not reset; contents are never visible while empty, since tx_data is gated.
   always_ff @(posedge clock) begin
      if (push_ok) fifo_mem[wr_ptr] <= data[7:0];
   end

   // NOTE: non-blocking assignments throughout sequential logic so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (overflow_set)
            overflow <= 1'b1;
         else if (wr && sel == REG_STATUS && data[3])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt         <= '0;
         cmp         <= '1;
         timer_en    <= 1'b0;
         irq_en      <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         if (cnt_wr)
            cnt <= data;
         else if (match)
            cnt <= '0;
         else if (timer_en)
            cnt <= cnt + 64'd1;

         if (wr && sel == REG_TIMER_CMP) cmp <= data;

         if (ctrl_wr) begin
            timer_en <= data[0];
            irq_en   <= data[1];
         end

         // A match in the same cycle as a software clear must not lose the new event.
         if (match)
            irq_pending <= 1'b1;
         else if (ctrl_wr && data[2])
            irq_pending <= 1'b0;
      end
   end

   // NOTE: default assigned first so the read mux cannot infer a latch.
   always_comb begin
      datain = '0;
      if (rd) begin
         case (sel)
            REG_STATUS:    datain = {48'b0, 8'(count), 4'b0, overflow, irq_pending, full, empty};
            REG_TIMER_CNT: datain = cnt;
            REG_TIMER_CMP: datain = cmp;
            REG_CTRL:      datain = {62'b0, irq_en, timer_en};
            default:       datain = '0;
         endcase
      end
   end

endmodule
